// File: rtl/mod_inv_ctrl_if.sv
// Request/response bundle between the point-arithmetic sequencer (master)
// and the modular inversion controller (slave).
interface mod_inv_ctrl_if #(
    parameter int unsigned WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] p_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output a_in,
        output p_in,
        input  busy,
        input  done,
        input  err,
        input  result
    );

    modport slave (
        input  start,
        input  a_in,
        input  p_in,
        output busy,
        output done,
        output err,
        output result
    );
endinterface

// File: rtl/mod_inv_ctrl.sv
// Binary extended Euclid modular inverse sequencer: result = a^-1 mod p.
// One reduction step per clock on u/v/x1/x2; p is latched at start.
// Optional build macro MOD_INV_TIMEOUT_EN adds a step counter that aborts
// with err after MAX_ITER RUN cycles (covers gcd(a,p) != 1 and bad inputs).
module mod_inv_ctrl #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned MAX_ITER = 1030
) (
    input logic           clk,
    input logic           rst_n,
    mod_inv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_u, w_u_d;
    logic [WIDTH-1:0] r_v, w_v_d;
    logic [WIDTH-1:0] r_x1, w_x1_d;
    logic [WIDTH-1:0] r_x2, w_x2_d;
    logic [WIDTH-1:0] r_p, w_p_d;
    logic [WIDTH-1:0] r_result, w_result_d;
    logic             r_err, w_err_d;

`ifdef MOD_INV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_ITER + 1);
    logic [CNT_W-1:0] r_count, w_count_d;
`else
    logic w_unused_max_iter;
    assign w_unused_max_iter = ^MAX_ITER;
`endif

    // x/2 mod p: odd x gets p added first; the sum keeps its carry bit before the shift.
    function automatic logic [WIDTH-1:0] f_halve(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH:0] w_sum;
        if (x[0]) begin
            w_sum = {1'b0, x} + {1'b0, p};
        end else begin
            w_sum = {1'b0, x};
        end
        w_sum = w_sum >> 1;
        return w_sum[WIDTH-1:0];
    endfunction

    // (a - b) mod p for a, b in [0, p-1]: add p back when the subtraction borrows.
    function automatic logic [WIDTH-1:0] f_sub_mod(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] p);
        logic [WIDTH:0] w_diff;
        w_diff = {1'b0, a} - {1'b0, b};
        if (w_diff[WIDTH]) begin
            return w_diff[WIDTH-1:0] + p;
        end
        return w_diff[WIDTH-1:0];
    endfunction

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_p      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
`ifdef MOD_INV_TIMEOUT_EN
            r_count  <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_u      <= w_u_d;
            r_v      <= w_v_d;
            r_x1     <= w_x1_d;
            r_x2     <= w_x2_d;
            r_p      <= w_p_d;
            r_result <= w_result_d;
            r_err    <= w_err_d;
`ifdef MOD_INV_TIMEOUT_EN
            r_count  <= w_count_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, one prioritised reduction step per RUN cycle.
    always_comb begin
        w_state_d  = r_state;
        w_u_d      = r_u;
        w_v_d      = r_v;
        w_x1_d     = r_x1;
        w_x2_d     = r_x2;
        w_p_d      = r_p;
        w_result_d = r_result;
        w_err_d    = 1'b0;
`ifdef MOD_INV_TIMEOUT_EN
        w_count_d  = r_count;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.a_in == '0) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_u_d     = bus.a_in;
                        w_v_d     = bus.p_in;
                        w_p_d     = bus.p_in;
                        w_x1_d    = WIDTH'(1);
                        w_x2_d    = '0;
                        w_state_d = StRun;
`ifdef MOD_INV_TIMEOUT_EN
                        w_count_d = '0;
`endif
                    end
                end
            end
            StRun: begin
`ifdef MOD_INV_TIMEOUT_EN
                w_count_d = r_count + 1'b1;
`endif
                if (r_u == WIDTH'(1)) begin
                    w_result_d = r_x1;
                    w_state_d  = StFin;
                end else if (r_v == WIDTH'(1)) begin
                    w_result_d = r_x2;
                    w_state_d  = StFin;
`ifdef MOD_INV_TIMEOUT_EN
                end else if (r_count == CNT_W'(MAX_ITER - 1)) begin
                    w_err_d   = 1'b1;
                    w_state_d = StIdle;
`endif
                end else if (!r_u[0]) begin
                    w_u_d  = r_u >> 1;
                    w_x1_d = f_halve(r_x1, r_p);
                end else if (!r_v[0]) begin
                    w_v_d  = r_v >> 1;
                    w_x2_d = f_halve(r_x2, r_p);
                end else if (r_u >= r_v) begin
                    w_u_d  = r_u - r_v;
                    w_x1_d = f_sub_mod(r_x1, r_x2, r_p);
                end else begin
                    w_v_d  = r_v - r_u;
                    w_x2_d = f_sub_mod(r_x2, r_x1, r_p);
                end
            end
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.busy   = (r_state == StRun);
    assign bus.done   = (r_state == StFin);
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mod_inv_ctrl.sv
// Directed + random bench for mod_inv_ctrl; expected inverses come from
// Fermat exponentiation a^(p-2) mod p on prime moduli.
// With MOD_INV_TIMEOUT_EN defined the bench runs the small-modulus and timeout cases.
module tb_mod_inv_ctrl;

    localparam int unsigned W = 256;
`ifdef MOD_INV_TIMEOUT_EN
    localparam int unsigned MAXI = 16;
`else
    localparam int unsigned MAXI = 1030;
`endif
    localparam int LIMIT = 4 * W + 8;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    mod_inv_ctrl_if #(.WIDTH(W)) bus ();

    mod_inv_ctrl #(
        .WIDTH   (W),
        .MAX_ITER(MAXI)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] p);
        logic [2*W-1:0] t;
        t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, p};
        return W'(t);
    endfunction

    // Inverse for prime p via Fermat's little theorem.
    function automatic logic [W-1:0] inv_model(input logic [W-1:0] a, input logic [W-1:0] p);
        logic [W-1:0] e;
        logic [W-1:0] r;
        logic [W-1:0] base;
        e    = p - 2;
        r    = W'(1);
        base = a % p;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulmod(r, base, p);
            base = mulmod(base, base, p);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) for done/err; returns in the done cycle.
    // lat counts cycles inclusively from the start cycle to the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] p, output int lat);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.p_in  = p;
        lat       = 1;
        tick();
        bus.start = 1'b0;
        lat       = 2;
        while (!bus.done && !bus.err && lat < LIMIT) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int           lat;
        int           cyc;
        int           runs;
        logic         saw;
        logic [W-1:0] prev;
        logic [W-1:0] p25519;
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic [W-1:0] r1;

        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.p_in  = '0;
        p25519    = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_result", bus.result, 0);
        rst_n = 1'b1;
        tick();

        // p=7, a=3
        run_op(3, 7, lat);
        check("t1_done", bus.done, 1);
        check("t1_err", bus.err, 0);
        check("t1_result", bus.result, 5);
        check("t1_result_model", bus.result, inv_model(3, 7));
        check("t1_lat_bound", W'(lat <= 2 + 4 * W), 1);
        tick();
        check("t1_busy_after", bus.busy, 0);
        check("t1_done_pulse", bus.done, 0);

        // p=11, a=1: rule 1 on the first RUN cycle
        run_op(1, 11, lat);
        check("t2_done", bus.done, 1);
        check("t2_latency", W'(lat), 3);
        check("t2_result", bus.result, 1);
        tick();

        // a=0: err next cycle, result untouched
        prev      = bus.result;
        bus.start = 1'b1;
        bus.a_in  = '0;
        bus.p_in  = 11;
        tick();
        bus.start = 1'b0;
        check("t4_err", bus.err, 1);
        check("t4_done", bus.done, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_result", bus.result, prev);
        tick();
        check("t4_err_pulse", bus.err, 0);
        saw = 1'b0;
        repeat (3) begin
            tick();
            if (bus.done) saw = 1'b1;
        end
        check("t4_no_done", saw, 0);
        check("t4_result_held", bus.result, prev);

`ifndef MOD_INV_TIMEOUT_EN
        // p=2^255-19, a=2
        run_op(2, p25519, lat);
        check("t3_done", bus.done, 1);
        check("t3_half", bus.result, (p25519 >> 1) + 1);
        tick();

        for (int i = 0; i < 50; i++) begin
            a1 = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            a1 = a1 % p25519;
            if (a1 == '0) a1 = 1;
            run_op(a1, p25519, lat);
            check("t3_rand_done", bus.done, 1);
            check("t3_rand_product", mulmod(a1, bus.result, p25519), 1);
            check("t3_rand_model", bus.result, inv_model(a1, p25519));
            tick();
        end

        // start re-asserted mid-RUN with different operands is ignored
        a1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        a1 = (a1 % (p25519 - 2)) + 2;
        a2 = (a1 % 1000) + 3;
        r1 = inv_model(a1, p25519);
        bus.start = 1'b1;
        bus.a_in  = a1;
        bus.p_in  = p25519;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("t5_busy_mid", bus.busy, 1);
        bus.start = 1'b1;
        bus.a_in  = a2;
        bus.p_in  = 7;
        repeat (2) tick();
        bus.start = 1'b0;
        bus.a_in  = '0;
        cyc = 0;
        while (!bus.done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("t5_done", bus.done, 1);
        check("t5_first_result", bus.result, r1);

        // start during the done cycle is dropped; the following idle cycle accepts it
        bus.start = 1'b1;
        bus.a_in  = 1;
        bus.p_in  = 11;
        tick();
        check("t5_fin_start_ignored", bus.busy, 0);
        check("t5_fin_result_held", bus.result, r1);
        tick();
        bus.start = 1'b0;
        check("t5_accept_after_fin", bus.busy, 1);
        cyc = 0;
        while (!bus.done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("t5_second_done", bus.done, 1);
        check("t5_second_result", bus.result, 1);
        tick();

        // asynchronous reset mid-RUN
        bus.start = 1'b1;
        bus.a_in  = a2;
        bus.p_in  = p25519;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("t5_busy_before_rst", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_done", bus.done, 0);
        check("t5_rst_err", bus.err, 0);
        check("t5_rst_result", bus.result, 0);
        saw = 1'b0;
        repeat (3) begin
            tick();
            if (bus.done || bus.err) saw = 1'b1;
        end
        check("t5_rst_no_pulse", saw, 0);
        rst_n = 1'b1;
        tick();
        check("t5_idle_after_rst", bus.busy, 0);
`else
        // gcd(3,9)=3: never converges, times out after MAX_ITER RUN cycles
        bus.start = 1'b1;
        bus.a_in  = 3;
        bus.p_in  = 9;
        tick();
        bus.start = 1'b0;
        prev = bus.result;
        runs = 0;
        saw  = 1'b0;
        while (bus.busy && runs < 100) begin
            runs++;
            tick();
            if (bus.done) saw = 1'b1;
        end
        check("t6_run_cycles", W'(runs), W'(MAXI));
        check("t6_err", bus.err, 1);
        check("t6_no_done", saw, 0);
        check("t6_result_held", bus.result, prev);
        tick();
        check("t6_err_pulse", bus.err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
